// File: rtl/disp_scan_ctrl.sv
// Multiplex scan controller for a 4-digit hex display: frame-coherent snapshot of
// save1/save2, leading-zero blanking and whole-display blink.
module disp_scan_ctrl #(
   parameter int DIV          = 50000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] save1,
   input  logic [15:0] save2,
   input  logic        sel_req,
   input  logic        blank_lz,
   input  logic        blink_en,
   output logic [3:0]  digit_out,
   output logic [3:0]  an_n,
   output logic        sync,
   output logic        frame_done,
   output logic        cur_sel
);

   localparam int PW = $clog2(DIV);
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
   localparam logic [FW-1:0] FCNT_MAX  = FW'(BLINK_FRAMES - 1);

   logic [PW-1:0] presc_r;
   logic [1:0]    dig_r;
   logic [15:0]   snap_r;
   logic          lz_r;
   logic [FW-1:0] fcnt_r;
   logic          blink_ph_r;
   logic          first_r;

   logic          tick_s;
   logic          last_s;
   logic          bound_s;
   logic [3:0]    nib_s;
   logic          blank_s;
   logic          dark_s;

   // Scan timing decode, digit select and dark/blank decision.
   always_comb begin
      tick_s  = (presc_r == PRESC_MAX);
      last_s  = tick_s && (dig_r == 2'd3);
      bound_s = last_s || first_r;
      nib_s   = 4'h0;
      blank_s = 1'b0;
      case (dig_r)
         2'd0: begin
            nib_s   = snap_r[3:0];
            blank_s = 1'b0;
         end
         2'd1: begin
            nib_s   = snap_r[7:4];
            blank_s = lz_r && (snap_r[15:4] == 12'h000);
         end
         2'd2: begin
            nib_s   = snap_r[11:8];
            blank_s = lz_r && (snap_r[15:8] == 8'h00);
         end
         2'd3: begin
            nib_s   = snap_r[15:12];
            blank_s = lz_r && (snap_r[15:12] == 4'h0);
         end
         default: begin
            nib_s   = 4'h0;
            blank_s = 1'b1;
         end
      endcase
      // blink_en is live so releasing it un-darkens the display immediately.
      dark_s = first_r || (blink_en && blink_ph_r) || blank_s;
      if (dark_s) begin
         an_n      = 4'b1111;
         digit_out = 4'h0;
      end else begin
         an_n      = ~(4'b0001 << dig_r);
         digit_out = nib_s;
      end
   end

   // Prescaler, digit index, frame snapshot, pulses and blink cadence.
   always_ff @(posedge clk) begin
      if (reset) begin
         presc_r    <= '0;
         dig_r      <= 2'd0;
         snap_r     <= 16'h0000;
         cur_sel    <= 1'b0;
         lz_r       <= 1'b0;
         fcnt_r     <= '0;
         blink_ph_r <= 1'b0;
         first_r    <= 1'b1;
         sync       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         sync       <= bound_s;
         frame_done <= last_s;
         if (bound_s) begin
            snap_r  <= sel_req ? save2 : save1;
            cur_sel <= sel_req;
            lz_r    <= blank_lz;
            dig_r   <= 2'd0;
            presc_r <= '0;
            first_r <= 1'b0;
         end else if (tick_s) begin
            presc_r <= '0;
            dig_r   <= dig_r + 2'd1;
         end else begin
            presc_r <= presc_r + PW'(1);
         end
         // The startup boundary does not count as a completed frame.
         if (!blink_en) begin
            fcnt_r     <= '0;
            blink_ph_r <= 1'b0;
         end else if (bound_s && !first_r) begin
            if (fcnt_r == FCNT_MAX) begin
               fcnt_r     <= '0;
               blink_ph_r <= ~blink_ph_r;
            end else begin
               fcnt_r <= fcnt_r + FW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl: directed scenarios plus random traffic,
// compared every cycle against a cycle-count based reference model.
module tb_disp_scan_ctrl;

   localparam int DIV   = 4;
   localparam int BF    = 2;
   localparam int FRAME = 4 * DIV;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] save1 = 16'h0000;
   logic [15:0] save2 = 16'h0000;
   logic        sel_req = 1'b0;
   logic        blank_lz = 1'b0;
   logic        blink_en = 1'b0;
   logic [3:0]  digit_out;
   logic [3:0]  an_n;
   logic        sync;
   logic        frame_done;
   logic        cur_sel;

   int n_vec = 0;
   int n_err = 0;

   // Model: k counts cycles since the startup boundary (k==0 is the dark B cycle).
   int          k = 0;
   logic [15:0] m_snap = 16'h0000;
   logic        m_sel = 1'b0;
   logic        m_lz = 1'b0;
   int          m_bcnt = 0;

   disp_scan_ctrl #(.DIV(DIV), .BLINK_FRAMES(BF)) dut (
      .clk(clk), .reset(reset), .save1(save1), .save2(save2),
      .sel_req(sel_req), .blank_lz(blank_lz), .blink_en(blink_en),
      .digit_out(digit_out), .an_n(an_n), .sync(sync),
      .frame_done(frame_done), .cur_sel(cur_sel)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
      n_vec++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h (k=%0d)", tag, obs, exp_v, k);
      end
   endtask

   task automatic model_edge();
      if (reset) begin
         k      = 0;
         m_snap = 16'h0000;
         m_sel  = 1'b0;
         m_lz   = 1'b0;
         m_bcnt = 0;
      end else begin
         if (k % FRAME == 0) begin
            if (k != 0 && blink_en) m_bcnt++;
            m_snap = sel_req ? save2 : save1;
            m_sel  = sel_req;
            m_lz   = blank_lz;
         end
         if (!blink_en) m_bcnt = 0;
         k++;
      end
   endtask

   task automatic check_all();
      int          p, d;
      logic [3:0]  e_an, e_d;
      logic        e_sync, e_fd;
      logic [15:0] sh;
      bit          blanked, dark;
      if (k == 0) begin
         e_an = 4'b1111; e_d = 4'h0; e_sync = 1'b0; e_fd = 1'b0;
      end else begin
         p       = (k - 1) % FRAME;
         d       = p / DIV;
         e_sync  = (p == 0);
         e_fd    = (p == 0) && (k > FRAME);
         sh      = m_snap >> (4 * d);
         blanked = (d > 0) && m_lz && (sh == 16'h0000);
         dark    = (blink_en && ((m_bcnt / BF) % 2 == 1)) || blanked;
         e_an    = 4'b1111;
         e_d     = 4'h0;
         if (!dark) begin
            e_an[d] = 1'b0;
            e_d     = sh[3:0];
         end
      end
      chk("an_n", an_n, e_an);
      chk("digit_out", digit_out, e_d);
      chk("sync", {3'b000, sync}, {3'b000, e_sync});
      chk("frame_done", {3'b000, frame_done}, {3'b000, e_fd});
      chk("cur_sel", {3'b000, cur_sel}, {3'b000, m_sel});
   endtask

   task automatic tick_clk();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   // Advance at least one cycle, then until the scan sits at frame position p.
   task automatic goto_pos(input int p);
      int n = 0;
      tick_clk();
      while (!(k >= 1 && (k - 1) % FRAME == p) && n < 3 * FRAME) begin
         tick_clk();
         n++;
      end
   endtask

   initial begin
      logic [15:0] masks [4];
      masks[0] = 16'hFFFF; masks[1] = 16'h00FF; masks[2] = 16'h000F; masks[3] = 16'h0000;

      // Reset state
      repeat (3) tick_clk();
      chk("rst_an", an_n, 4'b1111);

      // Startup scan
      save1 = 16'h1234; sel_req = 1'b0; reset = 1'b0;
      tick_clk();
      chk("start_sync", {3'b000, sync}, 4'h1);
      chk("start_an0", an_n, 4'b1110);
      chk("start_d0", digit_out, 4'h4);
      goto_pos(4);  chk("start_an1", an_n, 4'b1101); chk("start_d1", digit_out, 4'h3);
      goto_pos(8);  chk("start_an2", an_n, 4'b1011); chk("start_d2", digit_out, 4'h2);
      goto_pos(12); chk("start_an3", an_n, 4'b0111); chk("start_d3", digit_out, 4'h1);
      goto_pos(0);
      chk("start_fd", {3'b000, frame_done}, 4'h1);
      chk("start_sync2", {3'b000, sync}, 4'h1);

      // Source switch mid-frame
      save2 = 16'hABCD;
      goto_pos(4); sel_req = 1'b1;
      goto_pos(12); chk("sw_old_d3", digit_out, 4'h1); chk("sw_old_sel", {3'b000, cur_sel}, 4'h0);
      goto_pos(0);  chk("sw_new_sel", {3'b000, cur_sel}, 4'h1); chk("sw_new_d0", digit_out, 4'hD);
      goto_pos(12); chk("sw_new_d3", digit_out, 4'hA);

      // Snapshot coherence
      sel_req = 1'b0;
      goto_pos(0);  chk("snap_d0", digit_out, 4'h4);
      goto_pos(8);  save1 = 16'h5678;
      goto_pos(12); chk("snap_hold_d3", digit_out, 4'h1);
      goto_pos(0);  chk("snap_new_d0", digit_out, 4'h8);

      // Leading-zero blanking
      blank_lz = 1'b1; save1 = 16'h0040;
      goto_pos(0);  chk("lz_an0", an_n, 4'b1110); chk("lz_d0", digit_out, 4'h0);
      goto_pos(4);  chk("lz_an1", an_n, 4'b1101); chk("lz_d1", digit_out, 4'h4);
      goto_pos(8);  chk("lz_an2", an_n, 4'b1111);
      goto_pos(12); chk("lz_an3", an_n, 4'b1111);
      save1 = 16'h0000;
      goto_pos(0);  chk("lz0_an0", an_n, 4'b1110); chk("lz0_d0", digit_out, 4'h0);
      goto_pos(4);  chk("lz0_an1", an_n, 4'b1111);
      blank_lz = 1'b0; save1 = 16'h1234;

      // Blink cadence
      goto_pos(0); blink_en = 1'b1;
      goto_pos(0); chk("blk_f2_lit", an_n, 4'b1110);
      goto_pos(0); chk("blk_f3_dark", an_n, 4'b1111);
      goto_pos(8); chk("blk_f3_dark_mid", an_n, 4'b1111);
      goto_pos(0);
      goto_pos(0); chk("blk_f5_lit", an_n, 4'b1110);
      goto_pos(0);
      goto_pos(0); chk("blk_f7_dark", an_n, 4'b1111);
      goto_pos(6); chk("blk_f7_dark6", an_n, 4'b1111);
      blink_en = 1'b0;
      tick_clk();  chk("blk_release", an_n, 4'b1101); chk("blk_release_d", digit_out, 4'h3);

      // Reset mid-frame
      sel_req = 1'b1;
      goto_pos(0); chk("rmf_sel", {3'b000, cur_sel}, 4'h1);
      goto_pos(8); reset = 1'b1;
      tick_clk();
      chk("rmf_an", an_n, 4'b1111);
      chk("rmf_sync", {3'b000, sync}, 4'h0);
      chk("rmf_cur_sel", {3'b000, cur_sel}, 4'h0);
      reset = 1'b0;
      tick_clk();
      chk("rmf_restart_sync", {3'b000, sync}, 4'h1);
      chk("rmf_restart_an", an_n, 4'b1110);

      // Random traffic with occasional resets and blink toggles
      for (int i = 0; i < 1500; i++) begin
         save1    = 16'($urandom) & masks[$urandom_range(0, 3)];
         save2    = 16'($urandom) & masks[$urandom_range(0, 3)];
         sel_req  = 1'($urandom);
         blank_lz = 1'($urandom);
         if ($urandom_range(0, 63) == 0) blink_en = ~blink_en;
         reset    = ($urandom_range(0, 96) == 0);
         tick_clk();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Scan controller for the calculator's 4-digit hex display. It sequences the digit multiplex at a parameterised refresh rate and picks `save1` or `save2` as the shown value. It latches a coherent snapshot at each frame boundary so the display never tears, and adds leading-zero blanking and whole-display blink. It sits between the calculator core (`save1`/`save2`, mode requests) and the 7-segment decoder and anode drivers.

## Interface
Parameters:
- `DIV`, 50000: clock cycles per digit period; must be at least 2.
- `BLINK_FRAMES`, 64: frames per blink half-period; must be at least 1.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `save1`, in, 16: operand/result register A.
- `save2`, in, 16: operand/result register B.
- `sel_req`, in, 1: requested source (0 = `save1`, 1 = `save2`). Sampled only at a frame boundary.
- `blank_lz`, in, 1: leading-zero blanking enable. Sampled only at a frame boundary.
- `blink_en`, in, 1: blink enable. Live input.
- `digit_out`, out, 4: nibble for the active digit.
- `an_n`, out, 4: active-low digit enables. One-hot low, or `4'b1111` when dark.
- `sync`, out, 1: one-cycle pulse on the first cycle of each frame.
- `frame_done`, out, 1: one-cycle pulse marking completion of a full 4-digit frame.
- `cur_sel`, out, 1: source currently displayed.

## Operation
**State.** The block holds:
- prescaler `presc` (0..DIV-1);
- digit index `dig` (0..3);
- 16-bit `snap`, latched `cur_sel`, latched `lz_l`;
- frame counter `fcnt` (0..BLINK_FRAMES-1) and `blink_ph`;
- `first` flag, set by reset.

**Reset.** While `reset` is high, every register clears and `first` is set to 1. Output values under reset: `an_n=4'b1111`, `digit_out=0`, `sync=0`, `frame_done=0`, `cur_sel=0`.

**Tick.** `tick = (presc == DIV-1)`. On tick, `presc` wraps to 0; otherwise it increments.

**Digit advance.** On tick, `dig` increments, wrapping 3 -> 0.

**Frame boundary B.** B = `(tick && dig==3) || first`. On B:
- `snap` <= (`sel_req` ? `save2` : `save1`);
- `cur_sel` <= `sel_req`;
- `lz_l` <= `blank_lz`;
- `dig` <= 0, `presc` <= 0, `first` <= 0;
- `sync` <= 1.

**Pulses.** `sync` is a registered pulse, high only in the cycle after B. `frame_done` is registered as `tick && dig==3`, so it never fires at startup and otherwise coincides with `sync`.

**Leading-zero blanking.** Digit i (i = 1..3) is blanked when `lz_l` is set and `snap` nibbles i..3 are all zero. Digit 0 is never blanked.

**Blink.**
- While `blink_en` is 0: `fcnt=0` and `blink_ph=0`.
- While `blink_en` is 1, at each non-startup B: if `fcnt==BLINK_FRAMES-1`, then `fcnt` <= 0 and `blink_ph` toggles; otherwise `fcnt` increments.

**Display outputs.** `digit_out` and `an_n` are combinational from registered state.
- Dark condition = `first`, or (`blink_en` && `blink_ph`), or the active digit is blanked.
- When dark: `an_n=4'b1111` and `digit_out=0`.
- Otherwise: `an_n=~(4'b0001<<dig)` and `digit_out=snap[4*dig+3:4*dig]`.

**Boundary conditions.**
- Changes to `sel_req`, `blank_lz`, `save1` or `save2` mid-frame have no visible effect until the next B.
- `reset` mid-frame takes priority over all other activity. On release, the block restarts exactly as after power-up.
- `blink_en` deasserted makes the display visible on the next cycle.

## Timing
- The first cycle after reset release is B. On the next cycle `sync=1`, digit 0 is shown from the new snapshot, and it holds for `DIV` cycles.
- Each digit is shown for `DIV` cycles. A frame is `4*DIV` cycles.
- `sync` and `frame_done` are each exactly 1 cycle wide.
- Source and data latency: a change becomes visible at the next frame start, at most `4*DIV+1` cycles later.
- Blink cadence: `BLINK_FRAMES` frames visible, then `BLINK_FRAMES` frames dark.

## Test plan
All scenarios use `DIV=4`, `BLINK_FRAMES=2`.

- **Startup scan.** Reset, then `save1=16'h1234`, `sel_req=0`. Required: one cycle after release, `sync=1`. Then `an_n` steps 1110/1101/1011/0111, 4 cycles each, with `digit_out` 4,3,2,1. `frame_done` and `sync` pulse 16 cycles after the first `sync`.
- **Source switch.** `save2=16'hABCD`; toggle `sel_req` to 1 during digit 1. Required: the current frame still shows 1234. The next frame shows D,C,B,A, with `cur_sel=1` at its `sync`.
- **Snapshot.** Change `save1` from 1234 to 5678 during digit 2. Required: digit 3 shows 1, and the following frame shows 8,7,6,5.
- **Leading-zero blanking.** `blank_lz=1`, `save1=16'h0040`. Required: digits 2 and 3 have `an_n=1111`; digit 1 shows 4; digit 0 shows 0. With `save1=0`, only digit 0 is lit, showing 0.
- **Blink.** `blink_en=1`. Required: frames 1-2 lit, frames 3-4 all `an_n=1111`, frames 5-6 lit. Deassert `blink_en` mid-dark: lit on the next cycle.
- **Reset mid-frame.** Assert `reset` during digit 2. Required: next edge gives `an_n=1111`, `sync=0`, `cur_sel=0`. After release, restart at digit 0 with a `sync` pulse.
